// File: rtl/sevseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevseg_scan_ctrl
//
// Time-multiplexed driver for a bank of common-anode/common-cathode seven
// segment digits. A free-running divider produces one scan tick per digit
// slot; on every tick the controller moves to the next digit and presents
// that digit's hex glyph, decimal point and one-hot anode select. A shadow
// register holds the displayed value so the host can change `value` freely and
// commit it with a single `load` strobe.
//
// Per-digit darkening sources: blank_mask (always dark), blink_mask (dark in
// blink phase 1) and leading-zero blanking (digit 0 is never blanked by it).
// A dark slot drives anodes, segments and dp all inactive.
//
// All display outputs are registered: they reflect the digit index, shadow,
// masks and blink phase sampled on the previous clock edge.
//
// Parameters
//   N_DIGITS   number of multiplexed digits (1..16)
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   BLINK_DIV  scan ticks per blink half-period (>= 1)
//   ACTIVE_LOW 1: anodes, segments and dp are driven active-low
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   value       packed hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   load        one-cycle strobe capturing value into the shadow register
//   blank_mask  bit i = 1 forces digit i dark
//   blink_mask  bit i = 1 darkens digit i while the blink phase is 1
//   dp_mask     bit i = 1 lights the decimal point on digit i
//   lzb_en      enables leading-zero blanking
//   segments    segments[0] = a ... segments[6] = g
//   dp          decimal point
//   anodes      one-hot digit select at the active level
//   scan_tick   one-cycle pulse marking each digit advance
// -----------------------------------------------------------------------------
module sevseg_scan_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 250,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  lzb_en,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  scan_tick
);

  // Counter widths; each is at least one bit so degenerate parameter values
  // (one digit, BLINK_DIV of 1) still yield legal vectors.
  localparam int DIV_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IDX_W = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // Output polarity: XOR-ing an active-high pattern with POL yields the pin
  // level, and the all-POL pattern is the inactive (dark) level.
  localparam logic                POL      = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{POL}};
  localparam logic [6:0]          SEG_OFF  = {7{POL}};

  // ---------------------------------------------------------------------------
  // Hex to seven-segment glyph, active-high, bit 0 = segment a.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F; // a b c d e f
      4'h1:    seg = 7'h06; // b c
      4'h2:    seg = 7'h5B; // a b d e g
      4'h3:    seg = 7'h4F; // a b c d g
      4'h4:    seg = 7'h66; // b c f g
      4'h5:    seg = 7'h6D; // a c d f g
      4'h6:    seg = 7'h7D; // a c d e f g
      4'h7:    seg = 7'h07; // a b c
      4'h8:    seg = 7'h7F; // all
      4'h9:    seg = 7'h6F; // a b c d f g
      4'hA:    seg = 7'h77; // a b c e f g
      4'hB:    seg = 7'h7C; // c d e f g
      4'hC:    seg = 7'h39; // a d e f
      4'hD:    seg = 7'h5E; // b c d e g
      4'hE:    seg = 7'h79; // a d e f g
      default: seg = 7'h71; // F: a e f g
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_q,       div_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q,  blink_ph_d;
  logic [4*N_DIGITS-1:0] shadow_q,    shadow_d;
  logic [6:0]            seg_q,       seg_d;
  logic                  dp_q,        dp_d;
  logic [N_DIGITS-1:0]   an_q,        an_d;

  // The tick is a pure decode of the divider flop, so it is glitch-free and
  // low throughout reset (the divider is held at 0 and SCAN_DIV >= 2).
  logic tick;
  assign tick = (div_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Slot timing: divider, digit index, blink counter/phase, shadow capture
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    div_d       = div_q + DIV_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    shadow_d    = load ? value : shadow_q;

    if (tick) begin
      div_d = '0;
      // With a single digit IDX_LAST is 0, so the index never leaves 0.
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode for the currently selected digit
  // ---------------------------------------------------------------------------
  logic [N_DIGITS-1:0] zero_above; // bit i: nibble i and every nibble above are 0
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_blink;
  logic                cur_dp;
  logic                cur_lz;
  logic [N_DIGITS-1:0] cur_onehot;
  logic                dark;

  always_comb begin
    zero_above = '0;
    zero_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (shadow_q[4*i +: 4] == 4'h0);
      zero_above[i] = zero_run;
    end

    cur_nib    = '0;
    cur_blank  = 1'b0;
    cur_blink  = 1'b0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    cur_onehot = '0;
    // A compare-per-digit mux keeps the select width-exact for any N_DIGITS,
    // including counts that are not a power of two.
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib       = shadow_q[4*i +: 4];
        cur_blank     = blank_mask[i];
        cur_blink     = blink_mask[i];
        cur_dp        = dp_mask[i];
        // The rightmost digit always shows, so a value of zero reads "0".
        cur_lz        = (i != 0) && zero_above[i];
        cur_onehot[i] = 1'b1;
      end
    end

    dark = cur_blank | (cur_blink & blink_ph_q) | (lzb_en & cur_lz);

    if (dark) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = POL;
    end else begin
      an_d  = cur_onehot ^ AN_OFF;
      seg_d = hex_to_seg(cur_nib) ^ SEG_OFF;
      dp_d  = cur_dp ^ POL;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      // NOTE: the shadow register is storage, but it is reset anyway: after
      // release the display must show a defined "0", never stale contents.
      shadow_q    <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= POL;
      an_q        <= AN_OFF;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign segments  = seg_q;
  assign dp        = dp_q;
  assign anodes    = an_q;
  assign scan_tick = tick;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sevseg_scan_ctrl
//
// Scoreboard bench for sevseg_scan_ctrl with N_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2, ACTIVE_LOW=1. The stimulus process applies one directed vector
// per scan tick and pushes the hand-computed expected slot contents; the
// monitor samples each slot two cycles after its tick and pops/compares.
// Slot k of the table starts on tick k+1 after reset, so it shows digit
// (k+1)%4 with blink phase ((k+1)/2)%2.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] value;
  logic          load;
  logic [ND-1:0] blank_mask, blink_mask, dp_mask;
  logic          lzb_en;
  logic [6:0]    segments;
  logic          dp;
  logic [ND-1:0] anodes;
  logic          scan_tick;

  sevseg_scan_ctrl #(
    .N_DIGITS  (ND),
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .lzb_en    (lzb_en),
    .segments  (segments),
    .dp        (dp),
    .anodes    (anodes),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [3:0]  dpm;
    logic        lzb;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpx;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpx;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void add(input logic ld, input logic [15:0] val,
                              input logic [3:0] bl, input logic [3:0] bk,
                              input logic [3:0] dm, input logic lz,
                              input logic [3:0] an, input logic [6:0] seg,
                              input logic dpx);
    vec_t v;
    v.ld = ld; v.val = val; v.blank = bl; v.blink = bk; v.dpm = dm; v.lzb = lz;
    v.an = an; v.seg = seg; v.dpx = dpx;
    vecs.push_back(v);
  endfunction

  // Bounded wait for the next scan tick, sampled on falling edges.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4 * SD; n++) begin
      @(negedge clk);
      if (scan_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tick_timeout", 16'd0, 16'd1);
  endtask

  // Monitor: one-hot anodes every cycle, slot contents two cycles after a tick.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("anode_onehot", ($countones(~anodes) <= 1) ? 16'd1 : 16'd0, 16'd1);
        if (scan_tick) begin
          @(negedge clk);
          @(negedge clk);
          if (sb_q.size() == 0) begin
            check("sb_underflow", 16'd0, 16'd1);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("slot%0d{an,seg,dp}", e.id),
                  {4'h0, anodes, segments, dp}, {4'h0, e.an, e.seg, e.dpx});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    int c;
    exp_t e;

    //   ld  value    blank blink dpm  lzb  an    seg    dp
    add(1, 16'h12AF, 4'h0, 4'h0, 4'h0, 0, 4'hD, 7'h08, 1); // 0  d1 A
    add(0, 16'h12AF, 4'h0, 4'h0, 4'h0, 0, 4'hB, 7'h24, 1); // 1  d2 2
    add(0, 16'h12AF, 4'h0, 4'h0, 4'h0, 0, 4'h7, 7'h79, 1); // 2  d3 1
    add(0, 16'h12AF, 4'h0, 4'h0, 4'h0, 0, 4'hE, 7'h0E, 1); // 3  d0 F
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 4'hD, 7'h08, 1); // 4  no load: still A
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 4'hB, 7'h24, 1); // 5  still 2
    add(1, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 4'h7, 7'h40, 1); // 6  load on tick: 0
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 0, 4'hE, 7'h40, 1); // 7
    add(1, 16'h0050, 4'h0, 4'h0, 4'h0, 1, 4'hD, 7'h12, 1); // 8  lzb d1 5
    add(0, 16'h0050, 4'h0, 4'h0, 4'h0, 1, 4'hF, 7'h7F, 1); // 9  d2 dark
    add(0, 16'h0050, 4'h0, 4'h0, 4'h0, 1, 4'hF, 7'h7F, 1); // 10 d3 dark
    add(0, 16'h0050, 4'h0, 4'h0, 4'h0, 1, 4'hE, 7'h40, 1); // 11 d0 0
    add(1, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 4'hF, 7'h7F, 1); // 12 all zero
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 4'hF, 7'h7F, 1); // 13
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 4'hF, 7'h7F, 1); // 14
    add(0, 16'h0000, 4'h0, 4'h0, 4'h0, 1, 4'hE, 7'h40, 1); // 15 d0 always lit
    add(1, 16'h1005, 4'h0, 4'h0, 4'h0, 1, 4'hD, 7'h40, 1); // 16 inner zero lit
    add(0, 16'h1005, 4'h0, 4'h0, 4'h0, 1, 4'hB, 7'h40, 1); // 17
    add(0, 16'h1005, 4'h0, 4'h0, 4'h0, 1, 4'h7, 7'h79, 1); // 18
    add(0, 16'h1005, 4'h0, 4'h0, 4'h0, 1, 4'hE, 7'h12, 1); // 19
    add(1, 16'h3210, 4'h0, 4'h1, 4'h2, 0, 4'hD, 7'h79, 0); // 20 ph0, dp on d1
    add(0, 16'h3210, 4'h0, 4'h1, 4'h2, 0, 4'hB, 7'h24, 1); // 21 ph1, d2 not blinking
    add(0, 16'h3210, 4'h0, 4'h1, 4'h2, 0, 4'h7, 7'h30, 1); // 22 ph1
    add(0, 16'h3210, 4'h0, 4'h1, 4'h2, 0, 4'hE, 7'h40, 1); // 23 ph0, d0 lit
    add(0, 16'h3210, 4'h0, 4'hF, 4'h2, 0, 4'hD, 7'h79, 0); // 24 ph0 lit
    add(0, 16'h3210, 4'h0, 4'hF, 4'h2, 0, 4'hF, 7'h7F, 1); // 25 ph1 dark
    add(0, 16'h3210, 4'h0, 4'hF, 4'h2, 0, 4'hF, 7'h7F, 1); // 26 ph1 dark
    add(0, 16'h3210, 4'h0, 4'hF, 4'h2, 0, 4'hE, 7'h40, 1); // 27 ph0 lit
    add(0, 16'h3210, 4'h2, 4'h0, 4'h2, 0, 4'hF, 7'h7F, 1); // 28 blanked: no dp
    add(0, 16'h3210, 4'h0, 4'h0, 4'hF, 0, 4'hB, 7'h24, 0); // 29
    add(1, 16'h8DB9, 4'h0, 4'h0, 4'h0, 0, 4'h7, 7'h00, 1); // 30 d3 8
    add(0, 16'h8DB9, 4'h0, 4'h0, 4'h0, 0, 4'hE, 7'h10, 1); // 31 d0 9
    add(0, 16'h8DB9, 4'h0, 4'h0, 4'h0, 0, 4'hD, 7'h03, 1); // 32 d1 b
    add(0, 16'h8DB9, 4'h0, 4'h0, 4'h0, 0, 4'hB, 7'h21, 1); // 33 d2 d
    add(1, 16'hC4E6, 4'h0, 4'h0, 4'h0, 0, 4'h7, 7'h46, 1); // 34 d3 C
    add(0, 16'hC4E6, 4'h0, 4'h0, 4'h0, 0, 4'hE, 7'h02, 1); // 35 d0 6
    add(0, 16'hC4E6, 4'h0, 4'h0, 4'h0, 0, 4'hD, 7'h06, 1); // 36 d1 E
    add(0, 16'hC4E6, 4'h0, 4'h0, 4'h0, 0, 4'hB, 7'h19, 1); // 37 d2 4
    add(1, 16'h7005, 4'h0, 4'h0, 4'h0, 0, 4'h7, 7'h78, 1); // 38 d3 7
    add(0, 16'h7005, 4'h0, 4'h0, 4'h0, 0, 4'hE, 7'h12, 1); // 39 d0 5

    // Reset with a load pending: outputs inactive before any clock edge,
    // and the load must be ignored.
    reset = 1'b1; value = 16'hFFFF; load = 1'b1;
    blank_mask = '0; blink_mask = '0; dp_mask = '0; lzb_en = 1'b0;
    #2;
    check("rst_async_anodes", anodes, 16'hF);
    check("rst_async_seg", segments, 16'h7F);
    check("rst_async_dp", dp, 16'h1);
    check("rst_async_tick", scan_tick, 16'h0);
    repeat (3) @(negedge clk);
    check("rst_held_state", {anodes, segments, dp, scan_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});

    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    check("release_first_slot", {anodes, segments, dp}, {4'hE, 7'h40, 1'b1});
    mon_en = 1'b1;
    c = 1;
    while (!scan_tick && c < 4 * SD) begin
      @(negedge clk);
      c++;
    end
    // Divider restarts at 0, so the tick occupies the SCAN_DIV-th cycle.
    check("release_first_tick", 16'(c), 16'(SD - 1));

    ok = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      if (k > 0) begin
        wait_tick(ok);
        if (!ok) break;
      end
      value      = vecs[k].val;
      load       = vecs[k].ld;
      blank_mask = vecs[k].blank;
      blink_mask = vecs[k].blink;
      dp_mask    = vecs[k].dpm;
      lzb_en     = vecs[k].lzb;
      e.an = vecs[k].an; e.seg = vecs[k].seg; e.dpx = vecs[k].dpx; e.id = k;
      sb_q.push_back(e);
      @(negedge clk);
      load = 1'b0;
    end

    for (int n = 0; n < 4 * SD && sb_q.size() > 0; n++) @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    // Mid-slot reset: digit 1 of 0x7005 is lit, then reset blanks it at once.
    wait_tick(ok);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_slot", {anodes, segments, dp}, {4'hD, 7'h40, 1'b1});
    #2 reset = 1'b1;
    #1;
    check("midslot_rst_out", {anodes, segments, dp, scan_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Shadow cleared (digit 0 reads 0, not 5) and index restarted at 0.
    check("midslot_release_slot", {anodes, segments, dp}, {4'hE, 7'h40, 1'b1});
    c = 1;
    while (!scan_tick && c < 4 * SD) begin
      @(negedge clk);
      c++;
    end
    check("midslot_release_tick", 16'(c), 16'(SD - 1));
    @(negedge clk);
    @(negedge clk);
    check("midslot_next_slot", {anodes, segments, dp}, {4'hD, 7'h40, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
